// File: rtl/relu.sv
// Lane-parallel ReLU with a combinational output and a one-cycle registered copy
// that also reports which lanes were negative and how many.
module relu #(
  parameter int WIDTH = 16,
  parameter int N     = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [WIDTH-1:0] in        [0:N-1],
  input  logic                    in_valid,
  output logic signed [WIDTH-1:0] out       [0:N-1],
  output logic signed [WIDTH-1:0] out_q     [0:N-1],
  output logic                    out_valid,
  output logic [N-1:0]            neg_mask,
  output logic [$clog2(N+1)-1:0]  neg_count
);

  localparam int CW = $clog2(N + 1);

  logic signed [WIDTH-1:0] relu_val [0:N-1];
  logic [N-1:0]            neg_bits;
  logic [CW-1:0]           neg_sum;

  logic signed [WIDTH-1:0] data_d [0:N-1];
  logic signed [WIDTH-1:0] data_q [0:N-1];
  logic                    valid_d, valid_q;
  logic [N-1:0]            mask_d, mask_q;
  logic [CW-1:0]           count_d, count_q;

  // Only the MSB decides the sign, so zero and the most-positive value pass unchanged.
  always_comb begin
    neg_bits = '0;
    neg_sum  = '0;
    for (int i = 0; i < N; i++) begin
      neg_bits[i] = in[i][WIDTH-1];
      relu_val[i] = neg_bits[i] ? '0 : in[i];
      neg_sum     = neg_sum + CW'(neg_bits[i]);
    end
  end

  always_comb begin
    valid_d = in_valid;
    mask_d  = in_valid ? neg_bits : mask_q;
    count_d = in_valid ? neg_sum  : count_q;
    for (int i = 0; i < N; i++) begin
      data_d[i] = in_valid ? relu_val[i] : data_q[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      mask_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < N; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      mask_q  <= mask_d;
      count_q <= count_d;
      for (int i = 0; i < N; i++) begin
        data_q[i] <= data_d[i];
      end
    end
  end

  assign out       = relu_val;
  assign out_q     = data_q;
  assign out_valid = valid_q;
  assign neg_mask  = mask_q;
  assign neg_count = count_q;

endmodule

// File: tb/tb_relu.sv
// Randomized plus directed bench for relu, checked against an arithmetic reference model;
// a second small instance (WIDTH=8, N=1) covers the parameter corners.
module tb_relu;

   localparam int W  = 16;
   localparam int NL = 4;

   logic clk = 1'b0;
   logic rst;
   logic inValid;

   logic signed [W-1:0] dIn   [0:NL-1];
   logic signed [W-1:0] dOut  [0:NL-1];
   logic signed [W-1:0] dOutQ [0:NL-1];
   logic                dOutValid;
   logic [NL-1:0]       dNegMask;
   logic [2:0]          dNegCount;

   logic signed [7:0] sIn   [0:0];
   logic signed [7:0] sOut  [0:0];
   logic signed [7:0] sOutQ [0:0];
   logic              sOutValid;
   logic [0:0]        sNegMask;
   logic [0:0]        sNegCount;

   int checks   = 0;
   int failures = 0;

   // Reference state for the registered path of each instance
   int expQ [0:NL-1];
   int expMask;
   int expCnt;
   int expValid;
   int sExpQ;
   int sExpMask;
   int sExpValid;

   relu #(.WIDTH(W), .N(NL)) dut (
      .clk(clk), .rst(rst), .in(dIn), .in_valid(inValid),
      .out(dOut), .out_q(dOutQ), .out_valid(dOutValid),
      .neg_mask(dNegMask), .neg_count(dNegCount)
   );

   relu #(.WIDTH(8), .N(1)) dutSmall (
      .clk(clk), .rst(rst), .in(sIn), .in_valid(inValid),
      .out(sOut), .out_q(sOutQ), .out_valid(sOutValid),
      .neg_mask(sNegMask), .neg_count(sNegCount)
   );

   always #5 clk = ~clk;

   function automatic int reluRef(int x);
      return (x < 0) ? 0 : x;
   endfunction

   task automatic checkVal(string tag, logic signed [31:0] obs, logic signed [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
      end
   endtask

   // Compares both instances' combinational and registered outputs against the model
   task automatic checkOutput(string phase);
      for (int i = 0; i < NL; i++) begin
         checkVal($sformatf("%s out[%0d]", phase, i), dOut[i], reluRef(int'(dIn[i])));
         checkVal($sformatf("%s out_q[%0d]", phase, i), dOutQ[i], expQ[i]);
      end
      checkVal({phase, " out_valid"}, {31'd0, dOutValid}, expValid);
      checkVal({phase, " neg_mask"}, {28'd0, dNegMask}, expMask);
      checkVal({phase, " neg_count"}, {29'd0, dNegCount}, expCnt);
      checkVal({phase, " small out"}, sOut[0], reluRef(int'(sIn[0])));
      checkVal({phase, " small out_q"}, sOutQ[0], sExpQ);
      checkVal({phase, " small out_valid"}, {31'd0, sOutValid}, sExpValid);
      checkVal({phase, " small neg_mask"}, {31'd0, sNegMask}, sExpMask);
      checkVal({phase, " small neg_count"}, {31'd0, sNegCount}, sExpMask);
   endtask

   task automatic clearModel();
      for (int i = 0; i < NL; i++) expQ[i] = 0;
      expMask = 0; expCnt = 0; expValid = 0;
      sExpQ = 0; sExpMask = 0; sExpValid = 0;
   endtask

   // One clock with the given in_valid; inputs already set, checked on the falling edge
   task automatic applyStimulus(bit v, string phase);
      inValid = v;
      @(posedge clk);
      if (rst) begin
         clearModel();
      end else if (v) begin
         expMask = 0; expCnt = 0;
         for (int i = 0; i < NL; i++) begin
            expQ[i] = reluRef(int'(dIn[i]));
            if (int'(dIn[i]) < 0) begin
               expMask += (1 << i);
               expCnt++;
            end
         end
         expValid  = 1;
         sExpQ     = reluRef(int'(sIn[0]));
         sExpMask  = (int'(sIn[0]) < 0) ? 1 : 0;
         sExpValid = 1;
      end else begin
         expValid  = 0;
         sExpValid = 0;
      end
      @(negedge clk);
      checkOutput(phase);
   endtask

   task automatic setVec(int a, int b, int c, int d);
      dIn[0] = W'(a); dIn[1] = W'(b); dIn[2] = W'(c); dIn[3] = W'(d);
   endtask

   function automatic logic signed [W-1:0] pickVal();
      case ($urandom_range(0, 7))
         0: return 16'sh8000;
         1: return 16'sh7fff;
         2: return '0;
         3: return -16'sd1;
         default: return W'($urandom);
      endcase
   endfunction

   initial begin
      rst = 1'b1;
      inValid = 1'b0;
      setVec(5, -5, 0, 100);
      sIn[0] = 8'sd3;
      clearModel();
      #1 checkOutput("reset");
      @(negedge clk);
      rst = 1'b0;

      setVec(0, 1, 123, 32767);
      #1 checkOutput("nonneg comb");
      setVec(-1, -123, -32768, -5);
      sIn[0] = -8'sd128;
      applyStimulus(1'b1, "all negative");
      applyStimulus(1'b0, "all negative idle");

      setVec(0, 1, 123, 32767);
      sIn[0] = 8'sd127;
      applyStimulus(1'b1, "stream 1");
      setVec(-1, -123, -32768, -5);
      applyStimulus(1'b1, "stream 2");
      setVec(-10, 0, 20, -30);
      sIn[0] = 8'sd0;
      applyStimulus(1'b1, "stream 3");
      setVec(7, -7, 7, -7);
      applyStimulus(1'b0, "stream hold");
      applyStimulus(1'b0, "stream hold 2");

      for (int n = 0; n < 200; n++) begin
         for (int i = 0; i < NL; i++) dIn[i] = pickVal();
         sIn[0] = 8'($urandom);
         applyStimulus(1'($urandom_range(0, 2) != 0), "random");
      end

      setVec(-10, 0, 20, -30);
      applyStimulus(1'b1, "pre reset");
      #2 rst = 1'b1;
      clearModel();
      #1 checkOutput("async reset");
      setVec(300, -300, -1, 1);
      sIn[0] = -8'sd9;
      #1 checkOutput("reset comb tracks");
      applyStimulus(1'b1, "valid under reset");
      rst = 1'b0;
      applyStimulus(1'b0, "post reset idle");
      applyStimulus(1'b1, "first capture");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/relu.md
RELU -- requirements
Module: relu

Interface
REQ-001 Parameter WIDTH, default 16: bit width of each signed two's-complement lane.
REQ-002 Parameter N, default 4: number of lanes; legal range N >= 1.
REQ-003 clk  input  1  rising-edge clock for all registered outputs.
REQ-004 rst  input  1  reset, asynchronous and active-high; clears all registered state.
REQ-005 in  input  unpacked array [0:N-1] of signed [WIDTH-1:0]  input vector, lane index 0 first.
REQ-006 in_valid  input  1  qualifies "in" for the registered path.
REQ-007 out  output  unpacked array [0:N-1] of signed [WIDTH-1:0]  combinational ReLU of "in".
REQ-008 out_q  output  unpacked array [0:N-1] of signed [WIDTH-1:0]  registered ReLU of "in".
REQ-009 out_valid  output  1  high when out_q holds a result captured from a valid input.
REQ-010 neg_mask  output  [N-1:0]  registered; bit i = 1 when lane i of the captured vector was negative.
REQ-011 neg_count  output  [$clog2(N+1)-1:0]  registered population count of neg_mask.

Function
REQ-012 out[i] SHALL equal in[i] when in[i] >= 0, else 0, for every lane i independently; no clock and no reset dependency.
REQ-013 out SHALL settle within the same delta/time step as any change on "in".
REQ-014 Sign test SHALL use only the MSB of each lane (bit WIDTH-1); zero counts as non-negative and passes through unchanged.
REQ-015 Most-negative value (e.g. -32768 at WIDTH=16) SHALL map to 0; most-positive value (e.g. 32767) SHALL pass through unchanged; no saturation or width change.
REQ-016 On a rising clk edge with in_valid=1: out_q <= ReLU(in), neg_mask <= per-lane sign bits, neg_count <= popcount of those bits, out_valid <= 1.
REQ-017 On a rising clk edge with in_valid=0: out_q, neg_mask and neg_count SHALL hold; out_valid <= 0.
REQ-018 Registered-path latency SHALL be exactly 1 cycle from the in_valid sample to out_valid/out_q.
REQ-019 Back-to-back valid inputs SHALL be accepted every cycle; there is no backpressure.
REQ-020 neg_count SHALL range 0..N inclusive without overflow.
REQ-021 The registered path SHALL use the same ReLU function as "out", so out_q equals the value "out" had at the capturing edge.

Reset
REQ-022 While rst=1, asynchronously: out_q = all lanes 0, neg_mask = 0, neg_count = 0, out_valid = 0.
REQ-023 rst SHALL NOT affect the combinational output "out".
REQ-024 Reset asserted mid-stream SHALL discard any pending result. The first capture after deassertion occurs on the first rising edge with rst=0 and in_valid=1.

Verification
REQ-025 All non-negative: in = {0, 1, 123, 32767} -> out = {0, 1, 123, 32767} within the same time step.
REQ-026 All negative: in = {-1, -123, -32768, -5} -> out = {0, 0, 0, 0}. With in_valid=1 for one edge: out_q = {0,0,0,0}, neg_mask = 4'b1111, neg_count = 4, out_valid = 1 for one cycle.
REQ-027 Mixed: in = {-10, 0, 20, -30} -> out = {0, 0, 20, 0}. Registered: neg_mask = 4'b1001, neg_count = 2.
REQ-028 Streaming: three consecutive valid vectors from REQ-025..027 -> out_q follows each one a cycle later and out_valid stays high for 3 cycles. Then in_valid=0 -> out_valid = 0 and out_q holds {0, 0, 20, 0}.
REQ-029 Async reset: assert rst between clock edges while out_valid=1 -> out_q, neg_mask, neg_count and out_valid clear immediately, and out still tracks "in".
REQ-030 Parameter sweep: WIDTH=8, N=1 with in = {-128} -> out = {0}, neg_count = 1; with in = {127} -> out = {127}, neg_count = 0.
